// File: rtl/mul_pkg.sv
// Shared types for the radix-4 Booth partial-product generator: Booth selects,
// skid-buffer states and the row-count derivation.
package mul_pkg;

  typedef enum logic [2:0] {
    SEL_ZERO,
    SEL_POS1,
    SEL_POS2,
    SEL_NEG1,
    SEL_NEG2
  } booth_sel_t;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } skid_state_t;

  function automatic int pp_num(input int num_w);
    return num_w / 2;
  endfunction

  // Group bits are (b[2j+1], b[2j], b[2j-1]).
  function automatic booth_sel_t booth_decode(input logic [2:0] grp);
    booth_sel_t sel;
    case (grp)
      3'b001, 3'b010: sel = SEL_POS1;
      3'b011:         sel = SEL_POS2;
      3'b100:         sel = SEL_NEG2;
      3'b101, 3'b110: sel = SEL_NEG1;
      default:        sel = SEL_ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mul_booth2_enc.sv
// One Booth row: maps a 3-bit multiplier group and the multiplicand to a
// (W+1)-bit one's-complement row plus the +1 correction bit.
module mul_booth2_enc
  import mul_pkg::*;
#(
  parameter int P_NUM_W = 16
) (
  input  logic [2:0]         grp,
  input  logic [P_NUM_W-1:0] num_a,
  output logic [P_NUM_W:0]   row,
  output logic               neg
);

  booth_sel_t           sel;
  logic [P_NUM_W:0]     mag;

  always_comb begin
    sel = booth_decode(grp);
    mag = '0;
    neg = 1'b0;
    case (sel)
      SEL_POS1: mag = {num_a[P_NUM_W-1], num_a};
      SEL_POS2: mag = {num_a, 1'b0};
      SEL_NEG1: begin
        mag = {num_a[P_NUM_W-1], num_a};
        neg = 1'b1;
      end
      SEL_NEG2: begin
        mag = {num_a, 1'b0};
        neg = 1'b1;
      end
      default: mag = '0;
    endcase
    // Negative rows are ~kA; the missing +1 travels on neg.
    row = neg ? ~mag : mag;
  end

endmodule

// File: rtl/mul_booth2_pp_gen.sv
// Radix-4 Booth partial-product generator with a registered 2-entry skid
// buffer on the output (OUT drives the ports, SKID holds the overflow set).
module mul_booth2_pp_gen
  import mul_pkg::*;
#(
  parameter int P_NUM_W = 16
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst,
  input  logic                                    i_valid,
  output logic                                    o_ready,
  input  logic [P_NUM_W-1:0]                      i_num_a,
  input  logic [P_NUM_W-1:0]                      i_num_b,
  output logic                                    o_valid,
  input  logic                                    i_ready,
  output logic [pp_num(P_NUM_W)*2*P_NUM_W-1:0]    o_pp,
  output logic [pp_num(P_NUM_W)-1:0]              o_neg
);

  localparam int PP_NUM = pp_num(P_NUM_W);
  localparam int ROW_W  = 2 * P_NUM_W;
  localparam int PP_W   = PP_NUM * ROW_W;

  // Handshake: a set moves when valid && ready are both high at a rising edge.
  logic [P_NUM_W:0] b_ext;
  logic [PP_W-1:0]  new_pp;
  logic [PP_NUM-1:0] new_neg;

  assign b_ext = {i_num_b, 1'b0};

  for (genvar j = 0; j < PP_NUM; j++) begin : g_row
    logic [P_NUM_W:0] row;
    logic [ROW_W-1:0] row_ext;

    mul_booth2_enc #(.P_NUM_W(P_NUM_W)) u_enc (
      .grp   (b_ext[2*j +: 3]),
      .num_a (i_num_a),
      .row   (row),
      .neg   (new_neg[j])
    );

    assign row_ext                = {{(P_NUM_W-1){row[P_NUM_W]}}, row};
    assign new_pp[j*ROW_W +: ROW_W] = row_ext << (2*j);
  end

  skid_state_t       state;
  skid_state_t       state_nx;
  logic              in_fire;
  logic              out_fire;
  logic [PP_W-1:0]   skid_pp;
  logic [PP_NUM-1:0] skid_neg;

  assign in_fire  = i_valid && o_ready;
  assign out_fire = o_valid && i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= EMPTY;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      EMPTY: if (in_fire) state_nx = ONE;
      ONE: begin
        if (in_fire && !out_fire)      state_nx = FULL;
        else if (!in_fire && out_fire) state_nx = EMPTY;
      end
      FULL:  if (out_fire) state_nx = ONE;
      default: state_nx = EMPTY;
    endcase
  end

  // Both flags decode the state register only, so ready never sees i_ready.
  always_comb begin
    o_valid = (state == ONE) || (state == FULL);
    o_ready = (state == EMPTY) || (state == ONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_pp     <= '0;
      o_neg    <= '0;
      skid_pp  <= '0;
      skid_neg <= '0;
    end else begin
      case (state)
        EMPTY: if (in_fire) begin
          o_pp  <= new_pp;
          o_neg <= new_neg;
        end
        ONE: begin
          if (in_fire && out_fire) begin
            o_pp  <= new_pp;
            o_neg <= new_neg;
          end else if (in_fire) begin
            skid_pp  <= new_pp;
            skid_neg <= new_neg;
          end
        end
        FULL: if (out_fire) begin
          o_pp  <= skid_pp;
          o_neg <= skid_neg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mul_booth2_pp_gen.md
Name: mul_booth2_pp_gen

Overview:
Radix-4 Booth partial-product generator for a signed P_NUM_W x P_NUM_W multiplier.
It sits directly upstream of the per-bit 8-input Wallace tree columns. Each cycle it accepts one operand pair and emits P_NUM_W/2 rows, each pre-shifted and sign-extended to 2*P_NUM_W bits. It also emits one negation-correction bit per row.
The datapath is registered behind a valid/ready handshake with a 2-entry skid buffer, giving full throughput and breaking the ready path.

Parameters:
- P_NUM_W, 16, operand width. Must be even and >= 4. Row count P_PP_NUM = P_NUM_W/2, which is 8 at the default and matches the Wallace column fan-in.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  synchronous active-high reset.
- i_valid  input  1  operand pair valid.
- o_ready  output  1  block can accept an operand pair this cycle.
- i_num_a  input  P_NUM_W  multiplicand, two's complement.
- i_num_b  input  P_NUM_W  multiplier, two's complement.
- o_valid  output  1  partial-product set valid.
- i_ready  input  1  downstream accepts the set this cycle.
- o_pp  output  P_PP_NUM*2*P_NUM_W  rows; row j occupies bits [j*2W +: 2W].
- o_neg  output  P_PP_NUM  per-row correction; bit j weighs 2^(2j).

Behaviour:
- Booth encoding:
  - Group j takes (b[2j+1], b[2j], b[2j-1]), with b[-1] = 0.
  - 000, 111 -> 0.
  - 001, 010 -> +A.
  - 011 -> +2A.
  - 100 -> -2A.
  - 101, 110 -> -A.
- Magnitude: kA is formed in P_NUM_W+1 bits (2A = A<<1, which is exact in W+1 bits).
- Row value:
  - Positive or zero: row = kA, neg = 0.
  - Negative: row = ~(kA), neg = 1. The group 111 is zero, so it has row = 0 and neg = 0.
  - The row is then sign-extended from W+1 to 2W bits, shifted left by 2j, and truncated to 2W bits.
- Invariant: sum over j of (row_j + (o_neg[j] << 2j)) mod 2^(2W) == A*B as a signed 2W-bit value.
- Handshake:
  - Input fires on i_valid && o_ready; output fires on o_valid && i_ready.
  - Latency is 1 cycle: a pair accepted in cycle n is presented at o_* in cycle n+1 if the output register is free.
- Skid buffer, with entries OUT (drives the ports) and SKID:
  - Output register states: EMPTY, ONE (OUT valid), FULL (OUT and SKID valid).
  - EMPTY + input fire -> ONE.
  - ONE + input fire only -> FULL.
  - ONE + output fire only -> EMPTY.
  - ONE + both fire -> ONE, with OUT loaded with the new set.
  - FULL + output fire -> ONE, with SKID moving to OUT. No input fire is possible in FULL.
- o_ready is registered: it is 1 in EMPTY and ONE, and 0 in FULL. It must not depend combinationally on i_ready.
- o_pp and o_neg hold stable while o_valid && !i_ready.
- Order is strictly FIFO and no set is ever dropped or duplicated.
- Reset:
  - o_valid = 0, o_ready = 1, o_pp = 0, o_neg = 0, state = EMPTY.
  - Inputs are ignored during the reset cycle.
  - A reset mid-operation discards both entries.
- Boundary cases:
  - A = -2^(W-1) with select ±2A must be exact.
  - B = -1 must produce only row 0 non-zero.

Decomposition:
- Package mul_pkg holds:
  - typedef enum for the Booth select, with values SEL_ZERO, SEL_POS1, SEL_POS2, SEL_NEG1, SEL_NEG2;
  - the FSM state enum (EMPTY, ONE, FULL);
  - a P_PP_NUM derivation function.
- One combinational sub-module, mul_booth2_enc, maps one 3-bit group plus A to one (W+1)-bit row and a neg bit. It is instantiated P_PP_NUM times via generate.
- The skid/FSM logic lives in the top module.

Test Plan:
- A=3, B=5, i_ready=1 -> one cycle later: row0 = 0x00000003, row1 = 0x0000000C, other rows 0, o_neg = 0x00; the sum is 15.
- A=7, B=0xFFFF -> row0 = 0xFFFFFFF8, o_neg = 0x01, other rows 0; sum = 0xFFFFFFF9 (-7).
- A=0x8000, B=0x0002 -> row0 = 0x0000FFFF, row1 = 0xFFFE0000, o_neg = 0x01; sum = 0xFFFF0000 (-65536).
- Back-to-back 3 pairs with i_ready held low:
  - o_ready drops to 0 after 2 accepts;
  - on raising i_ready the sets emerge in order, one per cycle;
  - o_ready returns to 1 the cycle after the first output fire.
- i_rst asserted with FULL state -> next cycle o_valid = 0, o_ready = 1; the held sets never appear.
- 10k random signed pairs with random i_valid/i_ready -> the scoreboard invariant holds for every output fire, and the output count equals the input count.
